// File: rtl/oc_led_shifter.sv
// Serialises a parallel LED word MSB-first into an external shift/storage register pair.
// Optional feature: define OC_LED_SHIFTER_CHANGE_DETECT_EN to send frames only when ledIn changes.

module oc_led_shifter #(
   parameter int LedCount     = 1,
   parameter int ShiftDivider = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [LedCount-1:0] ledIn,
   output logic                ledSclk,
   output logic                ledSdata,
   output logic                ledLatch,
   output logic                busy,
   output logic                frameDone
);

   localparam int CountWidth = (LedCount > 1) ? $clog2(LedCount) : 1;
   localparam int DivWidth   = (ShiftDivider > 1) ? $clog2(ShiftDivider) : 1;

   localparam logic [CountWidth-1:0] LastBit   = CountWidth'(LedCount - 1);
   localparam logic [DivWidth-1:0]   DivReload = DivWidth'(ShiftDivider - 1);
   localparam logic [DivWidth-1:0]   DivOne    = DivWidth'(1);
   localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      HIGH,
      LATCH
   } stateT;

   stateT                 state;
   stateT                 stateNext;
   logic [DivWidth-1:0]   divCount;
   logic [DivWidth-1:0]   divNext;
   logic [CountWidth-1:0] bitCount;
   logic [CountWidth-1:0] bitCountNext;
   logic [LedCount-1:0]   shiftReg;
   logic [LedCount-1:0]   shiftNext;
   logic                  sdataNext;
   logic                  doneNext;
   logic                  divDone;
   logic                  startCond;

`ifdef OC_LED_SHIFTER_CHANGE_DETECT_EN
   logic [LedCount-1:0] lastSent;
   logic                firstFrame;

   // The first frame after reset is unconditional so the external register is known-good.
   assign startCond = firstFrame || (ledIn != lastSent);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lastSent   <= '0;
         firstFrame <= 1'b1;
      end else if (state == IDLE && startCond) begin
         lastSent   <= ledIn;
         firstFrame <= 1'b0;
      end
   end
`else
   assign startCond = 1'b1;
`endif

   assign divDone = (divCount == '0);

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      stateNext    = state;
      divNext      = divCount;
      bitCountNext = bitCount;
      shiftNext    = shiftReg;
      sdataNext    = ledSdata;
      doneNext     = 1'b0;

      case (state)
         IDLE: begin
            if (startCond) begin
               shiftNext    = ledIn;
               bitCountNext = LastBit;
               sdataNext    = ledIn[LedCount-1];
               divNext      = DivReload;
               stateNext    = SETUP;
            end
         end
         SETUP: begin
            if (divDone) begin
               divNext   = DivReload;
               stateNext = HIGH;
            end else begin
               divNext = divCount - DivOne;
            end
         end
         HIGH: begin
            if (divDone) begin
               divNext = DivReload;
               if (bitCount == '0) begin
                  stateNext = LATCH;
               end else begin
                  // Data only moves on the falling sclk edge, giving a full half-bit of setup.
                  shiftNext    = shiftReg << 1;
                  sdataNext    = shiftNext[LedCount-1];
                  bitCountNext = bitCount - CountOne;
                  stateNext    = SETUP;
               end
            end else begin
               divNext = divCount - DivOne;
            end
         end
         LATCH: begin
            if (divDone) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end else begin
               divNext = divCount - DivOne;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         divCount  <= '0;
         bitCount  <= '0;
         shiftReg  <= '0;
         ledSclk   <= 1'b0;
         ledSdata  <= 1'b0;
         ledLatch  <= 1'b0;
         busy      <= 1'b0;
         frameDone <= 1'b0;
      end else begin
         state     <= stateNext;
         divCount  <= divNext;
         bitCount  <= bitCountNext;
         shiftReg  <= shiftNext;
         // Outputs are decoded from the next state so they leave the block straight from flops.
         ledSclk   <= (stateNext == HIGH);
         ledSdata  <= sdataNext;
         ledLatch  <= (stateNext == LATCH);
         busy      <= (stateNext != IDLE);
         frameDone <= doneNext;
      end
   end

endmodule

// File: tb/tb_oc_led_shifter.sv
// Bench for oc_led_shifter: three instances (4x2, 1x1, 64x3) checked every cycle against a frame-timeline model.
// Builds with or without OC_LED_SHIFTER_CHANGE_DETECT_EN; the scenario adapts to the build.

module tb_oc_led_shifter;

   logic        clock;
   logic        reset;
   logic [3:0]  ledInA;
   logic [0:0]  ledInB;
   logic [63:0] ledInC;
   logic [2:0]  sclkV;
   logic [2:0]  sdataV;
   logic [2:0]  latchV;
   logic [2:0]  busyV;
   logic [2:0]  doneV;

   int vectors = 0;
   int fails   = 0;
   int cycle   = 0;

   // Model state per instance: ph is the cycle index inside the frame, -1 when idle.
   int          ph       [3];
   logic [63:0] snap     [3];
   logic        mDone    [3];
   logic        held     [3];
   logic        first    [3];
   logic [63:0] lastSent [3];

   // Per-frame measurements taken from the DUT outputs.
   logic [63:0] curBits   [3];
   int          curEdges  [3];
   int          curHigh   [3];
   int          curLatch  [3];
   int          curBusy   [3];
   logic [63:0] lastBits  [3];
   int          lastEdges [3];
   int          lastHigh  [3];
   int          lastLatch [3];
   int          lastBusy  [3];
   int          lastPeriod[3];
   int          doneCycle [3];
   int          frames    [3];
   logic        prevSclk  [3];
   logic        prevSdata [3];
   logic        prevReset = 1'b0;
   int          latchBeforeReset = -1;

   oc_led_shifter #(.LedCount(4), .ShiftDivider(2)) dutA (
      .clock(clock), .reset(reset), .ledIn(ledInA),
      .ledSclk(sclkV[0]), .ledSdata(sdataV[0]), .ledLatch(latchV[0]),
      .busy(busyV[0]), .frameDone(doneV[0])
   );

   oc_led_shifter #(.LedCount(1), .ShiftDivider(1)) dutB (
      .clock(clock), .reset(reset), .ledIn(ledInB),
      .ledSclk(sclkV[1]), .ledSdata(sdataV[1]), .ledLatch(latchV[1]),
      .busy(busyV[1]), .frameDone(doneV[1])
   );

   oc_led_shifter #(.LedCount(64), .ShiftDivider(3)) dutC (
      .clock(clock), .reset(reset), .ledIn(ledInC),
      .ledSclk(sclkV[2]), .ledSdata(sdataV[2]), .ledLatch(latchV[2]),
      .busy(busyV[2]), .frameDone(doneV[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int lcOf(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 64);
   endfunction

   function automatic int sdOf(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
   endfunction

   function automatic logic [63:0] inVec(input int d);
      if (d == 0) return {60'd0, ledInA};
      if (d == 1) return {63'd0, ledInB};
      return ledInC;
   endfunction

   function automatic logic startOk(input int d);
`ifdef OC_LED_SHIFTER_CHANGE_DETECT_EN
      return first[d] || (inVec(d) != lastSent[d]);
`else
      return 1'b1;
`endif
   endfunction

   // Expected {sclk, sdata, latch, busy, frameDone} from the position on the frame timeline.
   function automatic logic [4:0] expOut(input int d);
      int halfPair;
      int shiftSpan;
      int bitIdx;
      halfPair  = 2 * sdOf(d);
      shiftSpan = halfPair * lcOf(d);
      if (ph[d] < 0) return {1'b0, held[d], 1'b0, 1'b0, mDone[d]};
      if (ph[d] < shiftSpan) begin
         bitIdx = ph[d] / halfPair;
         return {((ph[d] % halfPair) >= sdOf(d)), snap[d][lcOf(d) - 1 - bitIdx], 1'b0, 1'b1, 1'b0};
      end
      return {1'b0, snap[d][0], 1'b1, 1'b1, 1'b0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic waitFrames(input int d, input int n, input int budget);
      int k;
      k = 0;
      while (frames[d] < n && k < budget) begin
         @(posedge clock);
         k++;
      end
      #2;
      if (frames[d] < n) begin
         vectors++;
         fails++;
         $display("FAIL wait_frames_dut%0d: frames=%0d, required=%0d", d, frames[d], n);
      end
   endtask

   task automatic waitPhaseA(input int p, input int budget);
      int k;
      k = 0;
      do begin
         @(posedge clock);
         #2;
         k++;
      end while (ph[0] != p && k < budget);
      if (ph[0] != p) begin
         vectors++;
         fails++;
         $display("FAIL wait_phase_dutA: phase=%0d, required=%0d", ph[0], p);
      end
   endtask

   // Compare process: checks outputs midway between edges, then advances the model one clock.
   initial begin
      for (int d = 0; d < 3; d++) begin
         frames[d]    = 0;
         doneCycle[d] = 0;
         lastPeriod[d] = 0;
      end
      forever begin
         @(negedge clock);
         cycle++;
         if (!reset) begin
            if (prevReset) latchBeforeReset = curLatch[0];
            for (int d = 0; d < 3; d++) begin
               ph[d] = -1; mDone[d] = 1'b0; held[d] = 1'b0;
               first[d] = 1'b1; lastSent[d] = '0; snap[d] = '0;
               curBits[d] = '0; curEdges[d] = 0; curHigh[d] = 0;
               curLatch[d] = 0; curBusy[d] = 0;
               prevSclk[d] = 1'b0; prevSdata[d] = 1'b0;
            end
         end
         for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_outputs_cycle%0d", d, cycle),
                  {59'd0, sclkV[d], sdataV[d], latchV[d], busyV[d], doneV[d]},
                  {59'd0, expOut(d)});
            if (reset && prevSclk[d] && sclkV[d])
               check($sformatf("dut%0d_sdata_stable_cycle%0d", d, cycle),
                     {63'd0, sdataV[d]}, {63'd0, prevSdata[d]});
         end
         if (reset) begin
            for (int d = 0; d < 3; d++) begin
               if (sclkV[d] && !prevSclk[d]) begin
                  curBits[d] = {curBits[d][62:0], sdataV[d]};
                  curEdges[d]++;
               end
               if (sclkV[d]) curHigh[d]++;
               if (latchV[d]) curLatch[d]++;
               if (busyV[d]) curBusy[d]++;
               if (doneV[d]) begin
                  lastBits[d] = curBits[d]; lastEdges[d] = curEdges[d];
                  lastHigh[d] = curHigh[d]; lastLatch[d] = curLatch[d];
                  lastBusy[d] = curBusy[d];
                  lastPeriod[d] = cycle - doneCycle[d];
                  doneCycle[d] = cycle;
                  frames[d]++;
                  curBits[d] = '0; curEdges[d] = 0; curHigh[d] = 0;
                  curLatch[d] = 0; curBusy[d] = 0;
               end
               prevSclk[d]  = sclkV[d];
               prevSdata[d] = sdataV[d];
               if (ph[d] < 0) begin
                  mDone[d] = 1'b0;
                  if (startOk(d)) begin
                     snap[d] = inVec(d); lastSent[d] = inVec(d);
                     first[d] = 1'b0; ph[d] = 0;
                  end
               end else begin
                  ph[d]++;
                  if (ph[d] == 2 * sdOf(d) * lcOf(d) + sdOf(d)) begin
                     ph[d] = -1; mDone[d] = 1'b1; held[d] = snap[d][0];
                  end
               end
            end
         end
         prevReset = reset;
      end
   end

   initial begin
      int fA;
      reset  = 1'b0;
      ledInB = 1'b1;
      ledInC = {32{2'b10}};
`ifdef OC_LED_SHIFTER_CHANGE_DETECT_EN
      ledInA = 4'b0011;
`else
      ledInA = 4'b1010;
`endif
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;

`ifdef OC_LED_SHIFTER_CHANGE_DETECT_EN
      waitFrames(0, 1, 100);
      check("cd_first_frame_bits", lastBits[0], 64'h3);
      check("cd_first_frame_busy", lastBusy[0], 18);
      repeat (1000) @(posedge clock);
      #2;
      check("cd_quiet_frames_a", frames[0], 1);
      check("cd_quiet_frames_b", frames[1], 1);
      check("cd_quiet_frames_c", frames[2], 1);
      check("cd_c_edges", lastEdges[2], 64);
      check("cd_c_bits", lastBits[2], 64'hAAAA_AAAA_AAAA_AAAA);
      check("cd_b_latch_cycles", lastLatch[1], 1);
      ledInA = 4'b0111;
      waitFrames(0, 2, 100);
      check("cd_change_frame_bits", lastBits[0], 64'h7);
      check("cd_change_frame_latch", lastLatch[0], 2);
      check("cd_change_frame_edges", lastEdges[0], 4);
`else
      waitFrames(0, 1, 100);
      check("a_frame1_bits", lastBits[0], 64'hA);
      check("a_frame1_edges", lastEdges[0], 4);
      check("a_frame1_latch_cycles", lastLatch[0], 2);
      check("a_frame1_busy_cycles", lastBusy[0], 18);
      check("b_sclk_high_cycles", lastHigh[1], 1);
      check("b_latch_cycles", lastLatch[1], 1);
      check("b_frame_period", lastPeriod[1], 4);
      check("b_bit", lastBits[1], 64'h1);

      waitPhaseA(5, 40);
      fA = frames[0];
      ledInA = 4'b0101;
      waitFrames(0, fA + 1, 40);
      check("a_snapshot_current_bits", lastBits[0], 64'hA);
      waitFrames(0, fA + 2, 40);
      check("a_snapshot_next_bits", lastBits[0], 64'h5);
      check("a_period", lastPeriod[0], 19);

      waitPhaseA(10, 40);
      fA = frames[0];
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      check("a_abort_no_latch", latchBeforeReset, 0);
      check("a_abort_no_frame_done", frames[0], fA);
      reset = 1'b1;
      waitFrames(0, fA + 1, 40);
      check("a_after_reset_bits", lastBits[0], 64'h5);
      check("a_after_reset_busy", lastBusy[0], 18);
      check("a_after_reset_latch", lastLatch[0], 2);

      fA = frames[2];
      waitFrames(2, fA + 1, 500);
      check("c_edges", lastEdges[2], 64);
      check("c_bits_msb_first", lastBits[2], 64'hAAAA_AAAA_AAAA_AAAA);
      check("c_sclk_high_cycles", lastHigh[2], 192);
      check("c_busy_cycles", lastBusy[2], 387);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/oc_led_shifter.md
OC_LED_SHIFTER -- requirements
Module: oc_led_shifter

Interface
REQ-001 The block SHALL have parameter LedCount, default 1, meaning number of LED bits per frame (range 1-64).
REQ-002 The block SHALL have parameter ShiftDivider, default 4, meaning clock cycles per serial half-bit (range 1-1023).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is synchronous to it.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-005 The block SHALL have port ledIn, input, LedCount, the parallel LED states produced by the LED controller.
REQ-006 The block SHALL have port ledSclk, output, 1, serial clock to an external shift register, which samples on the rising edge.
REQ-007 The block SHALL have port ledSdata, output, 1, serial data, MSB first.
REQ-008 The block SHALL have port ledLatch, output, 1, storage-register latch strobe, active high.
REQ-009 The block SHALL have port busy, output, 1, high whenever a frame is in progress.
REQ-010 The block SHALL have port frameDone, output, 1, one-cycle pulse when a frame completes.

Function
REQ-011 The block SHALL drive all outputs directly from flops.
REQ-012 The FSM SHALL have states IDLE, SETUP, HIGH and LATCH.
- SETUP: ledSclk=0.
- HIGH: ledSclk=1.
- LATCH: ledLatch=1.
- busy=1 in every state except IDLE.
REQ-013 In IDLE, when a start condition exists (REQ-021/022), the block SHALL, on that edge:
- snapshot ledIn into the shift register;
- load bitCount=LedCount-1;
- drive ledSdata=ledIn[LedCount-1];
- enter SETUP.
REQ-014 SETUP and HIGH SHALL each last exactly ShiftDivider cycles, timed by a divider counter that reloads on every state entry.
REQ-015 At the end of HIGH:
- if bitCount==0, the block SHALL enter LATCH;
- otherwise it SHALL shift the register left by one, present the new MSB on ledSdata, decrement bitCount and re-enter SETUP.
REQ-016 ledSdata SHALL change only on the cycle ledSclk falls (HIGH->SETUP) or at frame start, never while ledSclk=1.
REQ-017 LATCH SHALL last ShiftDivider cycles, then the block SHALL return to IDLE with frameDone=1 for exactly that one cycle.
REQ-018 Total frame length SHALL be 2*ShiftDivider*LedCount + ShiftDivider cycles of busy=1.
REQ-019 ledIn changes during a frame SHALL be ignored (snapshot semantics) and SHALL take effect in the next frame.
REQ-020 ledSdata SHALL hold its last value in LATCH and IDLE; ledSclk and ledLatch SHALL be 0 in IDLE.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force:
- ledSclk=0, ledSdata=0, ledLatch=0, busy=0, frameDone=0;
- FSM=IDLE;
- divider, bitCount and shift register to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with no latch pulse; the first frame after release SHALL start with a full snapshot.
REQ-025 The first frame SHALL not start before the first clock edge after reset=1.

Configuration
REQ-021 Without OC_LED_SHIFTER_CHANGE_DETECT_EN:
- the start condition SHALL always be true;
- IDLE SHALL last exactly one cycle, giving continuous refresh with period 2*ShiftDivider*LedCount + ShiftDivider + 1 cycles.
REQ-022 With OC_LED_SHIFTER_CHANGE_DETECT_EN defined, the block SHALL hold a LedCount-bit lastSent register.
- lastSent is updated with the snapshot at each frame start.
- The start condition is true for the first IDLE cycle after reset, or when ledIn != lastSent.
- Otherwise the block remains in IDLE indefinitely with busy=0.

Verification
REQ-026 Reset release test: LedCount=4, ShiftDivider=2, ledIn=4'b1010.
- ledSdata bits SHALL read 1,0,1,0 on ledSclk rising edges.
- ledLatch SHALL be high 2 cycles.
- busy SHALL be high 18 cycles.
- frameDone SHALL pulse once.
REQ-027 Mid-frame input change: ledIn changes 4'b1010->4'b0101 during bit 1 of a frame.
- The current frame SHALL still shift 1010.
- The next frame SHALL shift 0101.
REQ-028 Mid-frame reset: reset=0 asserted during HIGH of bit 2.
- All outputs SHALL be 0 in the same cycle.
- No ledLatch pulse SHALL occur.
- After release, a complete frame SHALL follow.
REQ-029 Minimum divider and edge counts: ShiftDivider=1, LedCount=1, ledIn=1.
- ledSclk SHALL be high for 1 cycle.
- ledLatch SHALL be high for 1 cycle.
- Frame period SHALL be 4 cycles without the macro.
REQ-030 Change-detect behaviour: with OC_LED_SHIFTER_CHANGE_DETECT_EN and ledIn held at 4'b0011.
- Exactly one frame SHALL occur after reset, then busy=0 for 1000 cycles.
- Changing ledIn to 4'b0111 SHALL start a new frame on the next IDLE cycle.
REQ-031 Maximum width: LedCount=64, ShiftDivider=3, alternating pattern.
- 64 rising edges SHALL occur per frame.
- The bit order SHALL be MSB first.
- ledSdata SHALL be stable throughout every ledSclk=1 interval.
